acq_controller: RTL and testbench

Sequencer for the acquisition datapath. Consumes the decoded command pulses from the command unit: reset, sample, set-decimation and clean-memory, plus a 4-bit parameter. It drives the sample-memory write port to either capture decimated ADC samples or zero-fill the memory. Sits between the command unit, the sample source and the sample RAM; reports busy/done/error back to the host-facing logic.

---
 rtl/acq_controller.sv | 129 ++++++++++++
 tb/tb_acq_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/acq_controller.sv
// Acquisition sequencer: turns command pulses into sample-memory writes,
// either zero-filling the memory or capturing decimated ADC samples.
module acq_controller #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_SIZE  = 10,
  parameter int MEM_DEPTH  = 1024,
  parameter int PARAM_SIZE = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_reset,
  input  logic                  i_cmd_sample,
  input  logic                  i_cmd_set_decim,
  input  logic                  i_cmd_clean_mem,
  input  logic [PARAM_SIZE-1:0] i_cmd_param,
  input  logic [DATA_SIZE-1:0]  i_sample_data,
  input  logic                  i_sample_valid,
  output logic                  o_mem_we,
  output logic [ADDR_SIZE-1:0]  o_mem_addr,
  output logic [DATA_SIZE-1:0]  o_mem_data,
  output logic [PARAM_SIZE-1:0] o_decim,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [1:0] {IDLE, CLEAN, CAPTURE, DONE} state_t;

  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

  state_t                state, state_nx;
  logic [ADDR_SIZE-1:0]  addr, addr_nx, waddr_nx;
  logic [PARAM_SIZE-1:0] decim_nx, dcnt, dcnt_nx;
  logic [DATA_SIZE-1:0]  wdata_nx;
  logic                  we_nx, busy_nx, done_nx, err_nx;
  logic                  cmd_any;

  // Non-reset commands: only meaningful in IDLE, an error elsewhere.
  assign cmd_any = i_cmd_clean_mem | i_cmd_sample | i_cmd_set_decim;

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    decim_nx = o_decim;
    dcnt_nx  = dcnt;
    waddr_nx = addr;
    wdata_nx = '0;
    we_nx    = 1'b0;
    busy_nx  = (state == CLEAN) || (state == CAPTURE);
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (i_cmd_reset) begin
      state_nx = IDLE;
      addr_nx  = '0;
      dcnt_nx  = '0;
      decim_nx = '0;
      busy_nx  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_cmd_clean_mem) begin
            addr_nx  = '0;
            state_nx = CLEAN;
          end else if (i_cmd_sample) begin
            addr_nx  = '0;
            dcnt_nx  = '0;
            state_nx = CAPTURE;
          end else if (i_cmd_set_decim) begin
            decim_nx = i_cmd_param;
          end
        end
        CLEAN: begin
          err_nx = cmd_any;
          we_nx  = 1'b1;
          if (addr == LAST) state_nx = DONE;
          else              addr_nx  = addr + 1'b1;
        end
        CAPTURE: begin
          err_nx = cmd_any;
          if (i_sample_valid) begin
            if (dcnt == '0) begin
              we_nx    = 1'b1;
              wdata_nx = i_sample_data;
              dcnt_nx  = o_decim;
              if (addr == LAST) state_nx = DONE;
              else              addr_nx  = addr + 1'b1;
            end else begin
              dcnt_nx = dcnt - 1'b1;
            end
          end
        end
        DONE: begin
          err_nx   = cmd_any;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Every output is the registered copy of this cycle's decision.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      dcnt       <= '0;
      o_decim    <= '0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      state      <= state_nx;
      addr       <= addr_nx;
      dcnt       <= dcnt_nx;
      o_decim    <= decim_nx;
      o_mem_we   <= we_nx;
      o_mem_addr <= waddr_nx;
      o_mem_data <= wdata_nx;
      o_busy     <= busy_nx;
      o_done     <= done_nx;
      o_error    <= err_nx;
    end
  end

endmodule

// File: tb/tb_acq_controller.sv
// Bench for acq_controller: mode/count reference model checked every cycle,
// plus directed scenarios with literal expectations on the captured writes.
module tb_acq_controller;
  localparam int DW = 8, AW = 4, DEPTH = 16, PW = 4;

  logic          clk = 0, rst_n = 1;
  logic          cmd_reset = 0, cmd_sample = 0, cmd_set_decim = 0, cmd_clean_mem = 0;
  logic [PW-1:0] cmd_param = 0;
  logic [DW-1:0] sdata = 0;
  logic          svalid = 0;
  logic          o_mem_we, o_busy, o_done, o_error;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic [PW-1:0] o_decim;

  acq_controller #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MEM_DEPTH(DEPTH), .PARAM_SIZE(PW)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_cmd_reset(cmd_reset), .i_cmd_sample(cmd_sample),
    .i_cmd_set_decim(cmd_set_decim), .i_cmd_clean_mem(cmd_clean_mem),
    .i_cmd_param(cmd_param), .i_sample_data(sdata), .i_sample_valid(svalid),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_decim(o_decim), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: mode 0 idle, 1 clean, 2 capture, 3 done.
  // Capture keeps sample k (counted from entry) when k mod (decim+1) == 0.
  int   m_mode = 0, m_dec = 0, m_nwr = 0, m_nval = 0;
  logic e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
  int   e_addr = 0, e_data = 0, e_dec = 0;

  initial forever begin
    @(posedge clk);
    e_we = 0; e_done = 0; e_err = 0;
    if (!rst_n) begin
      m_mode = 0; m_dec = 0; m_nwr = 0; m_nval = 0;
      e_busy = 0; e_addr = 0; e_data = 0;
    end else begin
      e_busy = (m_mode == 1 || m_mode == 2);
      if (cmd_reset) begin
        m_mode = 0; m_dec = 0; e_busy = 0;
      end else if (m_mode == 0) begin
        if (cmd_clean_mem) begin m_mode = 1; m_nwr = 0; end
        else if (cmd_sample) begin m_mode = 2; m_nwr = 0; m_nval = 0; end
        else if (cmd_set_decim) m_dec = int'(cmd_param);
      end else begin
        e_err = cmd_clean_mem | cmd_sample | cmd_set_decim;
        if (m_mode == 3) begin
          e_done = 1; m_mode = 0;
        end else begin
          if (m_mode == 1 || (svalid && (m_nval % (m_dec + 1)) == 0)) begin
            e_we = 1; e_addr = m_nwr;
            e_data = (m_mode == 1) ? 0 : int'(sdata);
            m_nwr++;
            if (m_nwr == DEPTH) m_mode = 3;
          end
          if (m_mode == 2 && svalid) m_nval++;
        end
      end
    end
    e_dec = m_dec;
  end

  // Write/done/error log used by the directed checks.
  int wa[$], wd[$];
  int done_cnt = 0, err_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (o_mem_we) begin wa.push_back(int'(o_mem_addr)); wd.push_back(int'(o_mem_data)); end
    if (o_done)  done_cnt++;
    if (o_error) err_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock: compare against the model at the falling edge, then step past it.
  task automatic cyc();
    @(negedge clk);
    chk("we", o_mem_we, e_we);
    chk("busy", o_busy, e_busy);
    chk("done", o_done, e_done);
    chk("error", o_error, e_err);
    chk("decim", o_decim, e_dec);
    if (e_we) begin
      chk("addr", o_mem_addr, e_addr);
      chk("data", o_mem_data, e_data);
    end
    #1;
  endtask

  task automatic cmd(input logic r, input logic c, input logic s, input logic d, input int p);
    cmd_reset = r; cmd_clean_mem = c; cmd_sample = s; cmd_set_decim = d; cmd_param = PW'(p);
    cyc();
    cmd_reset = 0; cmd_clean_mem = 0; cmd_sample = 0; cmd_set_decim = 0; cmd_param = 0;
  endtask

  task automatic chk_writes(input string nm, input int b, input int n, input int d0, input int step);
    chk({nm, "_count"}, wa.size() - b, n);
    for (int i = 0; i < n && b + i < wa.size(); i++) begin
      chk({nm, "_addr"}, wa[b+i], i);
      chk({nm, "_data"}, wd[b+i], d0 + step * i);
    end
  endtask

  int b, bd, be;

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_we", o_mem_we, 0);   chk("rst_addr", o_mem_addr, 0);
    chk("rst_data", o_mem_data, 0); chk("rst_decim", o_decim, 0);
    chk("rst_busy", o_busy, 0);   chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // Zero-fill
    b = wa.size(); bd = done_cnt; be = err_cnt;
    cmd(0, 1, 0, 0, 0);
    repeat (20) cyc();
    chk_writes("clean", b, 16, 0, 0);
    chk("clean_done", done_cnt - bd, 1);
    chk("clean_err", err_cnt - be, 0);

    // Decimation by 3 on back-to-back valids
    cmd(0, 0, 0, 1, 2);
    chk("decim_load", o_decim, 2);
    b = wa.size(); bd = done_cnt;
    cmd(0, 0, 1, 0, 0);
    for (int i = 0; i < 48; i++) begin svalid = 1; sdata = DW'(i); cyc(); end
    svalid = 0;
    repeat (4) cyc();
    chk_writes("dec2", b, 16, 0, 3);
    chk("dec2_done", done_cnt - bd, 1);

    // No decimation, sparse valids
    cmd(0, 0, 0, 1, 0);
    b = wa.size(); bd = done_cnt;
    cmd(0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      svalid = 1; sdata = DW'(8'hA0 + i); cyc();
      svalid = 0; cyc(); cyc();
    end
    repeat (4) cyc();
    chk_writes("dec0", b, 16, 8'hA0, 1);
    chk("dec0_done", done_cnt - bd, 1);

    // Rejected commands during capture
    b = wa.size(); bd = done_cnt; be = err_cnt;
    cmd(0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      svalid = 1; sdata = DW'(8'h40 + i);
      if (i == 3) begin cmd_set_decim = 1; cmd_param = 7; end
      if (i == 8) cmd_clean_mem = 1;
      cyc();
      svalid = 0; cmd_set_decim = 0; cmd_clean_mem = 0; cmd_param = 0;
      cyc();
    end
    repeat (4) cyc();
    chk("rej_err", err_cnt - be, 2);
    chk("rej_decim", o_decim, 0);
    chk_writes("rej", b, 16, 8'h40, 1);
    chk("rej_done", done_cnt - bd, 1);

    // Coincident pulses: sample beats set_decim, reset beats clean_mem
    cmd(0, 0, 0, 1, 1);
    b = wa.size(); bd = done_cnt; be = err_cnt;
    cmd_sample = 1; cmd_set_decim = 1; cmd_param = 5;
    cyc();
    cmd_sample = 0; cmd_set_decim = 0; cmd_param = 0;
    cyc(); cyc();
    chk("prio_busy", o_busy, 1);
    chk("prio_decim", o_decim, 1);
    chk("prio_err", err_cnt - be, 0);
    cmd(1, 1, 0, 0, 0);
    repeat (20) cyc();
    chk("prio_writes", wa.size() - b, 0);
    chk("prio_idle", o_busy, 0);
    chk("prio_decim0", o_decim, 0);
    chk("prio_err2", err_cnt - be, 0);
    chk("prio_done", done_cnt - bd, 0);

    // Asynchronous reset in the middle of a capture
    cmd(0, 0, 0, 1, 3);
    b = wa.size();
    cmd(0, 0, 1, 0, 0);
    for (int k = 0; k < 100 && wa.size() - b < 5; k++) begin svalid = 1; sdata = DW'(k); cyc(); end
    chk("mid_writes", wa.size() - b, 5);
    if (wa.size() - b >= 5) chk("mid_data4", wd[b+4], 16);
    rst_n = 0; svalid = 0;
    #1;
    chk("arst_we", o_mem_we, 0);   chk("arst_addr", o_mem_addr, 0);
    chk("arst_data", o_mem_data, 0); chk("arst_decim", o_decim, 0);
    chk("arst_busy", o_busy, 0);   chk("arst_done", o_done, 0);
    chk("arst_error", o_error, 0);
    repeat (3) cyc();
    rst_n = 1;
    bd = done_cnt; be = err_cnt;
    repeat (5) cyc();
    chk("arst_nodone", done_cnt - bd, 0);
    chk("arst_idle", o_busy, 0);
    cmd(0, 0, 0, 1, 4);
    cyc();
    chk("arst_decim_load", o_decim, 4);
    chk("arst_err", err_cnt - be, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
